// File: rtl/bsram_reader_pkg.sv
// Shared types and constants for the BSRAM read-back engine.
package bsram_pkg;

  localparam int unsigned BSRAM_ADDR_W = 11;
  localparam int unsigned BSRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic                    valid;
    logic [BSRAM_ADDR_W-1:0] adr;
    logic                    last;
  } rd_tag_t;

endpackage

// File: rtl/bsram_reader_if.sv
// BSRAM read port plus valid/ready output stream of the reader.
interface bsram_reader_if
  import bsram_pkg::*;
#(
  parameter int unsigned ADDR_W = BSRAM_ADDR_W,
  parameter int unsigned DATA_W = BSRAM_DATA_W
) ();

  logic              mem_ce;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_dout;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_adr;
  logic              m_last;

  modport master (
    output mem_ce, mem_wre, mem_adr,
    input  mem_dout,
    output m_valid, m_data, m_adr, m_last,
    input  m_ready
  );

  modport slave (
    input  mem_ce, mem_wre, mem_adr,
    output mem_dout,
    input  m_valid, m_data, m_adr, m_last,
    output m_ready
  );

endinterface

// File: rtl/bsram_reader_fifo.sv
// Synchronous power-of-2 FIFO with occupancy count; storage cleared on reset.
module word_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  // push while full is accepted only when a pop frees the slot in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/bsram_reader.sv
// Reads len words from BSRAM starting at base_adr and streams them out with backpressure.
module bsram_reader
  import bsram_pkg::*;
#(
  parameter int unsigned ADDR_W = BSRAM_ADDR_W,
  parameter int unsigned DATA_W = BSRAM_DATA_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FIFO_D = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  bsram_reader_if.master    bus
);

  localparam int unsigned FW = DATA_W + ADDR_W + 1;
  localparam int unsigned CW = $clog2(FIFO_D) + 1;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issue_cnt_q;
  rd_tag_t           pipe_q [RD_LAT];
  rd_tag_t           issue_tag;
  rd_tag_t           exit_tag;

  int unsigned       in_flight;
  logic              credit_ok;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic [FW-1:0]     fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  always_comb begin
    in_flight = 0;
    for (int unsigned i = 0; i < RD_LAT; i++) in_flight = in_flight + 32'(pipe_q[i].valid);
  end

  // reads in the latency pipe already own a FIFO slot, so the FIFO can never overflow
  assign credit_ok  = ((in_flight + 32'(fifo_count)) < FIFO_D) && !fifo_full;
  assign issue      = (state_q == ISSUE) && credit_ok;
  assign last_issue = (issue_cnt_q == len_q - 1'b1);

  assign bus.mem_ce  = issue;
  assign bus.mem_wre = 1'b0;
  assign bus.mem_adr = base_q + issue_cnt_q[ADDR_W-1:0];

  assign issue_tag = '{valid: 1'b1, adr: bus.mem_adr, last: last_issue};
  assign exit_tag  = pipe_q[RD_LAT-1];

  assign bus.m_valid = !fifo_empty;
  assign pop         = bus.m_valid && bus.m_ready;
  assign {bus.m_data, bus.m_adr, bus.m_last} = fifo_dout;

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == FIN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? FIN : ISSUE;
      ISSUE:   if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (pop && bus.m_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        base_q      <= base_adr;
        len_q       <= len;
        issue_cnt_q <= '0;
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= issue ? issue_tag : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (exit_tag.valid),
    .din   ({bus.mem_dout, exit_tag.adr, exit_tag.last}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
